// File: rtl/i2c_cmd_sequencer.sv
`timescale 1ns/1ps
// i2c_cmd_sequencer: waits out a power-up delay, writes a fixed init table,
// then forwards FIFO-buffered upstream samples, one I2C write frame per byte.
module i2c_cmd_sequencer #(
  parameter logic [6:0]  DEV_ADDR       = 7'h48,
  parameter int unsigned POWERUP_CYCLES = 16,
  parameter int unsigned INIT_LEN       = 2,
  parameter logic [63:0] INIT_BYTES     = 64'h0000_0000_0000_4003,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        i2c_ready,
  output logic        i2c_start,
  output logic [6:0]  i2c_addr,
  output logic [7:0]  i2c_data,
  output logic        init_done,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic [3:0]  fifo_level,
  output logic        err_timeout
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = 4;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned PWR_W = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
  localparam int unsigned TMO_W = 2;
  // Third consecutive cycle with the controller still idle after a start
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(2);

  typedef enum logic [2:0] {
    S_PWRUP      = 3'd0,
    S_INIT_ISSUE = 3'd1,
    S_IDLE       = 3'd2,
    S_WAIT_BUSY  = 3'd3,
    S_WAIT_DONE  = 3'd4,
    S_RESEND     = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [PWR_W-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             i2c_start_q, i2c_start_d;
  logic [7:0]       i2c_data_q, i2c_data_d;
  logic             init_done_q, init_done_d;
  logic             busy_q, busy_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             err_timeout_q, err_timeout_d;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  logic             push_c;
  logic             pop_c;
  logic [7:0]       init_byte_c;

  // Upstream handshake: accept whenever there is room and power-up is over
  assign in_ready = (level_q != LVL_W'(FIFO_DEPTH)) && (state_q != S_PWRUP);
  assign push_c   = in_valid && in_ready;

  // Current init table entry, byte 0 in the least significant position
  assign init_byte_c = INIT_BYTES[{init_idx_q[2:0], 3'b000} +: 8];

  assign i2c_addr    = DEV_ADDR;
  assign i2c_start   = i2c_start_q;
  assign i2c_data    = i2c_data_q;
  assign init_done   = init_done_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;
  assign fifo_level  = level_q;
  assign err_timeout = err_timeout_q;

  // Sequencer next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    pwr_cnt_d     = pwr_cnt_q;
    init_idx_d    = init_idx_q;
    tmo_cnt_d     = tmo_cnt_q;
    i2c_start_d   = 1'b0;
    i2c_data_d    = i2c_data_q;
    init_done_d   = init_done_q;
    busy_d        = busy_q;
    frame_count_d = frame_count_q;
    err_timeout_d = err_timeout_q;
    pop_c         = 1'b0;

    case (state_q)
      S_PWRUP: begin
        if (pwr_cnt_q == '0) begin
          if (INIT_LEN > 0) begin
            state_d = S_INIT_ISSUE;
          end else begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end
        end else begin
          pwr_cnt_d = pwr_cnt_q - PWR_W'(1);
        end
      end

      S_INIT_ISSUE: begin
        if (i2c_ready) begin
          i2c_data_d  = init_byte_c;
          i2c_start_d = 1'b1;
          busy_d      = 1'b1;
          tmo_cnt_d   = '0;
          state_d     = S_WAIT_BUSY;
        end
      end

      S_IDLE: begin
        if ((level_q != '0) && i2c_ready) begin
          pop_c       = 1'b1;
          i2c_data_d  = mem_q[rd_ptr_q];
          i2c_start_d = 1'b1;
          busy_d      = 1'b1;
          tmo_cnt_d   = '0;
          state_d     = S_WAIT_BUSY;
        end
      end

      // Reissue the sample already held in i2c_data after a missed start
      S_RESEND: begin
        if (i2c_ready) begin
          i2c_start_d = 1'b1;
          busy_d      = 1'b1;
          tmo_cnt_d   = '0;
          state_d     = S_WAIT_BUSY;
        end
      end

      S_WAIT_BUSY: begin
        if (!i2c_ready) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = init_done_q ? S_RESEND : S_INIT_ISSUE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end

      S_WAIT_DONE: begin
        if (i2c_ready) begin
          busy_d        = 1'b0;
          frame_count_d = frame_count_q + 16'd1;
          if (!init_done_q) begin
            init_idx_d = init_idx_q + IDX_W'(1);
            if ((init_idx_q + IDX_W'(1)) == IDX_W'(INIT_LEN)) begin
              init_done_d = 1'b1;
              state_d     = S_IDLE;
            end else begin
              state_d = S_INIT_ISSUE;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_PWRUP;
    endcase
  end

  // Sample FIFO pointer, level and storage update
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_PWRUP;
      pwr_cnt_q     <= PWR_W'(POWERUP_CYCLES - 1);
      init_idx_q    <= '0;
      tmo_cnt_q     <= '0;
      i2c_start_q   <= 1'b0;
      i2c_data_q    <= '0;
      init_done_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pwr_cnt_q     <= pwr_cnt_d;
      init_idx_q    <= init_idx_d;
      tmo_cnt_q     <= tmo_cnt_d;
      i2c_start_q   <= i2c_start_d;
      i2c_data_q    <= i2c_data_d;
      init_done_q   <= init_done_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // FIFO registers; contents are discarded on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
`timescale 1ns/1ps
// Bench for i2c_cmd_sequencer: I2C controller model plus an expected-byte queue.
module tb_i2c_cmd_sequencer;

  localparam int unsigned POWERUP_CYCLES = 16;
  localparam int unsigned FIFO_DEPTH     = 4;
  localparam logic [6:0]  DEV_ADDR       = 7'h48;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        i2c_ready = 1'b1;
  logic        i2c_start;
  logic [6:0]  i2c_addr;
  logic [7:0]  i2c_data;
  logic        init_done;
  logic        busy;
  logic [15:0] frame_count;
  logic [3:0]  fifo_level;
  logic        err_timeout;

  int total = 0;
  int bad   = 0;

  // Reference model: bytes expected on the bus, in order, and completed-frame count
  logic [7:0]  exp_q[$];
  logic [15:0] model_fc = 16'h0000;
  logic [7:0]  init_tbl[2] = '{8'h03, 8'h40};

  // Controller model state
  logic [7:0]  got_q[$];
  logic        ctl_busy = 1'b0;
  int          ctl_cnt = 0;
  int          ign_req = 0;
  int          ign_done = 0;
  logic [7:0]  ign_data = 8'h00;

  i2c_cmd_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .i2c_ready   (i2c_ready),
    .i2c_start   (i2c_start),
    .i2c_addr    (i2c_addr),
    .i2c_data    (i2c_data),
    .init_done   (init_done),
    .busy        (busy),
    .frame_count (frame_count),
    .fifo_level  (fifo_level),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // I2C write controller: takes a start while ready, stays busy 17..23 cycles
  always @(posedge clk) begin
    if (ctl_busy) begin
      if (ctl_cnt == 0) begin
        ctl_busy  <= 1'b0;
        i2c_ready <= 1'b1;
      end else begin
        ctl_cnt <= ctl_cnt - 1;
      end
    end else if (i2c_start && i2c_ready) begin
      if (ign_req != ign_done) begin
        ign_done <= ign_done + 1;
        ign_data <= i2c_data;
      end else begin
        ctl_busy  <= 1'b1;
        i2c_ready <= 1'b0;
        ctl_cnt   <= int'($urandom_range(22, 16));
        got_q.push_back(i2c_data);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic wait_got(input int n, output bit ok);
    int c = 0;
    while (got_q.size() < n && c < 400) begin
      @(negedge clk);
      c++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic wait_idle(output bit ok);
    int c = 0;
    ok = 1'b0;
    while (!ok && c < 400) begin
      @(negedge clk);
      ok = (busy === 1'b0) && (fifo_level === 4'd0);
      c++;
    end
  endtask

  task automatic push_byte(input logic [7:0] b, output bit ok, output bit stalled,
                           output logic [3:0] stall_lvl);
    int c = 0;
    stalled   = 1'b0;
    stall_lvl = 4'd0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && c < 400) begin
      stalled   = 1'b1;
      stall_lvl = fifo_level;
      @(negedge clk);
      c++;
    end
    ok = (in_ready === 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (ok) exp_q.push_back(b);
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({i2c_start, busy, init_done, err_timeout, in_ready} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000",
               {i2c_start, busy, init_done, err_timeout, in_ready});
    end
    total++;
    if (i2c_data !== 8'h00) begin
      bad++; $display("FAIL reset_data got=%h want=00", i2c_data);
    end
    total++;
    if (frame_count !== 16'h0000) begin
      bad++; $display("FAIL reset_frame_count got=%h want=0000", frame_count);
    end
    total++;
    if (fifo_level !== 4'd0) begin
      bad++; $display("FAIL reset_fifo_level got=%0d want=0", fifo_level);
    end
    total++;
    if (i2c_addr !== DEV_ADDR) begin
      bad++; $display("FAIL reset_addr got=%h want=%h", i2c_addr, DEV_ADDR);
    end
  endtask

  task automatic test_powerup_init();
    int base;
    int first = -1;
    bit ok, st;
    logic [3:0] sl;
    base = got_q.size();
    exp_q.delete();
    exp_q.push_back(init_tbl[0]);
    exp_q.push_back(init_tbl[1]);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 1; c <= 60 && first < 0; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++; $display("FAIL pwrup_in_ready got=%b want=0", in_ready);
        end
      end
      if (i2c_start === 1'b1) first = c;
    end
    total++;
    if (first != int'(POWERUP_CYCLES) + 1) begin
      bad++; $display("FAIL pwrup_first_start got=%0d want=%0d", first, POWERUP_CYCLES + 1);
    end
    total++;
    if (i2c_addr !== DEV_ADDR) begin
      bad++; $display("FAIL frame_addr got=%h want=%h", i2c_addr, DEV_ADDR);
    end
    push_byte(8'hA5, ok, st, sl);
    push_byte(8'h5A, ok, st, sl);
    @(negedge clk);
    total++;
    if ({fifo_level, init_done} !== {4'd2, 1'b0}) begin
      bad++; $display("FAIL init_buffering got=lvl%0d/done%b want=lvl2/done0", fifo_level, init_done);
    end
    wait_got(base + 3, ok);
    total++;
    if (!ok || init_done !== 1'b1 || frame_count !== 16'd2) begin
      bad++; $display("FAIL init_complete got=ok%b/done%b/fc%0d want=ok1/done1/fc2", ok, init_done, frame_count);
    end
    wait_got(base + 4, ok);
    wait_idle(ok);
    model_fc = model_fc + 16'(exp_q.size());
    total++;
    if (!ok || frame_count !== model_fc) begin
      bad++; $display("FAIL init_stream_count got=%0d want=%0d idle=%b", frame_count, model_fc, ok);
    end
    total++;
    if (got_q.size() != base + exp_q.size()) begin
      bad++; $display("FAIL init_stream_len got=%0d want=%0d", got_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (got_q[base + i] !== exp_q[i]) begin
        bad++; $display("FAIL init_stream_byte%0d got=%h want=%h", i, got_q[base + i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    bit ok, st;
    bit saw_full = 1'b0;
    logic [3:0] sl;
    base = got_q.size();
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      push_byte(8'($urandom), ok, st, sl);
      total++;
      if (!ok) begin
        bad++; $display("FAIL b2b_push%0d got=stuck want=accepted", i);
      end
      if (st) begin
        saw_full = 1'b1;
        total++;
        if (sl !== 4'(FIFO_DEPTH)) begin
          bad++; $display("FAIL b2b_stall_level got=%0d want=%0d", sl, FIFO_DEPTH);
        end
      end
    end
    total++;
    if (!saw_full) begin
      bad++; $display("FAIL b2b_backpressure got=none want=in_ready low at full");
    end
    wait_got(base + 6, ok);
    wait_idle(ok);
    model_fc = model_fc + 16'(exp_q.size());
    total++;
    if (!ok || frame_count !== model_fc) begin
      bad++; $display("FAIL b2b_count got=%0d want=%0d idle=%b", frame_count, model_fc, ok);
    end
    total++;
    if (got_q.size() != base + exp_q.size()) begin
      bad++; $display("FAIL b2b_len got=%0d want=%0d", got_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (got_q[base + i] !== exp_q[i]) begin
        bad++; $display("FAIL b2b_byte%0d got=%h want=%h", i, got_q[base + i], exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int base;
    int c = 0;
    bit ok, st;
    logic [3:0] sl;
    base = got_q.size();
    exp_q.delete();
    total++;
    if (err_timeout !== 1'b0) begin
      bad++; $display("FAIL tmo_initial got=%b want=0", err_timeout);
    end
    ign_req = ign_req + 1;
    push_byte(8'($urandom), ok, st, sl);
    while (err_timeout !== 1'b1 && c < 60) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (err_timeout !== 1'b1) begin
      bad++; $display("FAIL tmo_flag got=%b want=1", err_timeout);
    end
    wait_got(base + 1, ok);
    wait_idle(ok);
    model_fc = model_fc + 16'd1;
    total++;
    if (ign_data !== exp_q[0] || got_q.size() != base + 1 || got_q[base] !== exp_q[0]) begin
      bad++; $display("FAIL tmo_reissue got=ign%h/sent%h/n%0d want=%h/%h/1",
                      ign_data, got_q[base], got_q.size() - base, exp_q[0], exp_q[0]);
    end
    total++;
    if (err_timeout !== 1'b1 || frame_count !== model_fc) begin
      bad++; $display("FAIL tmo_after got=err%b/fc%0d want=err1/fc%0d", err_timeout, frame_count, model_fc);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok, st;
    bit early = 1'b0;
    logic [3:0] sl;
    base = got_q.size();
    exp_q.delete();
    push_byte(8'($urandom), ok, st, sl);
    wait_got(base + 1, ok);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL midrst_busy got=%b want=1", busy);
    end
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if ({i2c_start, busy, init_done, err_timeout, in_ready, i2c_data, frame_count, fifo_level} !== 33'd0) begin
      bad++; $display("FAIL midrst_outputs got=%b%b%b%b%b/%h/%h/%0d want=all zero",
                      i2c_start, busy, init_done, err_timeout, in_ready, i2c_data, frame_count, fifo_level);
    end
    total++;
    if (i2c_addr !== DEV_ADDR) begin
      bad++; $display("FAIL midrst_addr got=%h want=%h", i2c_addr, DEV_ADDR);
    end
    base = got_q.size();
    exp_q.delete();
    exp_q.push_back(init_tbl[0]);
    exp_q.push_back(init_tbl[1]);
    model_fc = 16'd0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 1; c <= int'(POWERUP_CYCLES); c++) begin
      @(posedge clk);
      #1;
      if (i2c_start === 1'b1) early = 1'b1;
    end
    total++;
    if (early) begin
      bad++; $display("FAIL midrst_powerup got=start inside delay want=none");
    end
    wait_got(base + 2, ok);
    wait_idle(ok);
    model_fc = model_fc + 16'd2;
    total++;
    if (got_q.size() != base + 2 || got_q[base] !== exp_q[0] || got_q[base + 1] !== exp_q[1]) begin
      bad++; $display("FAIL midrst_init got=%h,%h n=%0d want=%h,%h n=2",
                      got_q[base], got_q[base + 1], got_q.size() - base, exp_q[0], exp_q[1]);
    end
    total++;
    if (frame_count !== model_fc || init_done !== 1'b1) begin
      bad++; $display("FAIL midrst_count got=fc%0d/done%b want=fc%0d/done1", frame_count, init_done, model_fc);
    end
  endtask

  task automatic test_wrap();
    int base;
    bit ok, st;
    logic [3:0] sl;
    base = got_q.size();
    exp_q.delete();
    push_byte(8'($urandom), ok, st, sl);
    push_byte(8'($urandom), ok, st, sl);
    wait_got(base + 1, ok);
    @(negedge clk);
    force dut.frame_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.frame_count_q;
    model_fc = 16'hFFFE;
    wait_got(base + 2, ok);
    model_fc = model_fc + 16'd1;
    total++;
    if (frame_count !== model_fc) begin
      bad++; $display("FAIL wrap_ffff got=%h want=%h", frame_count, model_fc);
    end
    wait_idle(ok);
    model_fc = model_fc + 16'd1;
    total++;
    if (frame_count !== model_fc) begin
      bad++; $display("FAIL wrap_zero got=%h want=%h", frame_count, model_fc);
    end
    total++;
    if (got_q.size() != base + 2 || got_q[base] !== exp_q[0] || got_q[base + 1] !== exp_q[1]) begin
      bad++; $display("FAIL wrap_bytes got=%h,%h want=%h,%h", got_q[base], got_q[base + 1], exp_q[0], exp_q[1]);
    end
  endtask

  initial begin
    test_reset();
    test_powerup_init();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
- Command source sitting directly upstream of the I2C write controller.
- After reset, waits a power-up delay, then issues a fixed table of configuration bytes as I2C write frames.
- Then streams 8-bit samples from an upstream valid/ready source, buffered in a small FIFO, one I2C write frame per byte.
- Drives the controller's start/addr/data inputs and paces itself on the controller's ready output.

Parameters:
- DEV_ADDR, 7'h48, 7-bit I2C slave address used for every frame.
- POWERUP_CYCLES, 16, clk cycles held in S_PWRUP after reset before the first frame (min 1).
- INIT_LEN, 2, number of init bytes issued (0..8; 0 skips init).
- INIT_BYTES, 64'h0000_0000_0000_4003, init table; byte k = INIT_BYTES[8k+7:8k]; byte 0 is sent first.
- FIFO_DEPTH, 4, sample FIFO entries (power of two, 2..8).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- in_data  in  8  upstream sample byte
- in_valid  in  1  in_data valid
- in_ready  out  1  FIFO can accept; a transfer occurs when in_valid && in_ready at a rising edge
- i2c_ready  in  1  controller idle (high only when it can accept start)
- i2c_start  out  1  one-cycle start request to controller
- i2c_addr  out  7  frame address, constant DEV_ADDR
- i2c_data  out  8  frame data byte
- init_done  out  1  high once all init frames have completed
- busy  out  1  high from start issue until the frame completes
- frame_count  out  16  completed frames (init + sample), wraps at 16'hFFFF->0
- fifo_level  out  4  current FIFO occupancy, 0..FIFO_DEPTH
- err_timeout  out  1  sticky: controller failed to go busy after a start

Behaviour:
- Reset (async assert, sync release) values: state=S_PWRUP, i2c_start=0, i2c_data=0, init_done=0, busy=0, frame_count=0, fifo_level=0, err_timeout=0, FIFO pointers=0, in_ready=0.
- i2c_addr = DEV_ADDR at all times, including during reset.
- in_ready = (fifo_level != FIFO_DEPTH) && (state != S_PWRUP); combinational.
- Samples are accepted during init and buffered; they are not sent until init_done=1.

State machine (registered state):
- S_PWRUP: down-counter loads POWERUP_CYCLES-1 at reset. At zero: go to S_INIT_ISSUE if INIT_LEN>0, else set init_done=1 and go to S_IDLE.
- S_INIT_ISSUE: when i2c_ready=1, register i2c_data=INIT_BYTES[idx], i2c_start=1, busy=1, then go to S_WAIT_BUSY.
- S_IDLE: when fifo_level>0 and i2c_ready=1, pop FIFO head into i2c_data, i2c_start=1, busy=1, then go to S_WAIT_BUSY.
- S_WAIT_BUSY: i2c_start returns to 0 (exactly one cycle high). Wait for i2c_ready=0, then go to S_WAIT_DONE.
  - If i2c_ready is still 1 after 3 cycles in this state: set err_timeout=1 and return to the issuing state (retry the same byte; init idx is not advanced, the popped sample is held in i2c_data and reissued).
- S_WAIT_DONE: i2c_data is held stable. When i2c_ready=1: busy=0, frame_count+=1.
  - During init: idx+=1; if idx==INIT_LEN go to S_IDLE and set init_done=1, else go to S_INIT_ISSUE.
  - During streaming: go to S_IDLE.
- Latency: from the FIFO becoming non-empty in S_IDLE with i2c_ready=1, i2c_start rises on the next clk edge.

FIFO:
- Simultaneous push and pop in one cycle: level unchanged, both succeed.
- A push while full is impossible because in_ready=0.
- A pop while empty never occurs.
- Pointers wrap modulo FIFO_DEPTH.

Reset mid-frame:
- All outputs return to reset values immediately; the FIFO contents are discarded.
- The init sequence restarts from byte 0 after the power-up delay.

Test Plan:
- Reset release, POWERUP_CYCLES=16, INIT_LEN=2, controller model with ~20-cycle frames -> no i2c_start for 16 cycles; then start with i2c_data=8'h03, later start with 8'h40; init_done=1 and frame_count=2 after the second frame.
- Push 8'hA5, 8'h5A during init -> both held (fifo_level=2), sent in order after init_done; frame_count=4.
- Push 6 bytes back-to-back, FIFO_DEPTH=4, controller busy -> in_ready drops at level 4, no byte lost or duplicated, all 6 sent in order.
- Controller model ignores the first start (ready stays 1) -> err_timeout=1 after 3 cycles; same byte reissued; frame completes; err_timeout stays 1.
- Assert reset_n=0 mid-frame while busy=1 -> all outputs zero immediately; after release the power-up delay and init byte 0 repeat.
- Preload frame_count near 16'hFFFF via long run (or force) -> after one more completed frame it wraps to 0.
